// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 constants, KSA state encoding and sizing helpers.
package rc4_pkg;

    localparam int S_SIZE             = 256;
    localparam int DEFAULT_KEY_LENGTH = 3;
    // Cycles from a registered RAM address to valid q; the KSA FSM is built around 1.
    localparam int RAM_RD_LATENCY     = 1;

    typedef enum logic [2:0] {
        IDLE, RD_I, LATCH_I, RD_J, LATCH_J, WR_I, WR_J, DONE
    } ksa_state_t;

    function automatic int kidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// ksa_key_sel: selects key byte kidx from secret_key, byte 0 being the most significant.
module ksa_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH,
    localparam int KW = kidx_w(KEY_LENGTH)
) (
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [KW-1:0]           kidx,
    output logic [7:0]              key_byte
);

    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_LENGTH; k++)
            if (kidx == KW'(k)) key_byte = secret_key[8*(KEY_LENGTH-1-k) +: 8];
    end

endmodule

// File: rtl/ksa_shuffle.sv
// ksa_shuffle: RC4 key-scheduling swap pass over a 256x8 single-port S RAM.
module ksa_shuffle
    import rc4_pkg::*;
#(
    parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [7:0]              q,
    output logic [7:0]              address,
    output logic [7:0]              data,
    output logic                    wren,
    output logic                    busy,
    output logic                    done
);

    localparam int KW = kidx_w(KEY_LENGTH);

    ksa_state_t     state_q, state_d;
    logic [7:0]     i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]  kidx_q, kidx_d;
    logic [7:0]     key_byte;

    ksa_key_sel #(.KEY_LENGTH(KEY_LENGTH)) u_key_sel (
        .secret_key (secret_key),
        .kidx       (kidx_q),
        .key_byte   (key_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
        end
    end

    // RAM outputs are decoded from state so an async reset drops wren at once.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;
        address = '0;
        data    = '0;
        wren    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RD_I;
                i_d     = '0;
                j_d     = '0;
                kidx_d  = '0;
            end
            RD_I: begin
                address = i_q;
                state_d = LATCH_I;
            end
            LATCH_I: begin
                si_d    = q;
                j_d     = j_q + q + key_byte;
                state_d = RD_J;
            end
            RD_J: begin
                address = j_q;
                state_d = LATCH_J;
            end
            LATCH_J: begin
                sj_d    = q;
                state_d = WR_I;
            end
            WR_I: begin
                address = i_q;
                data    = sj_q;
                wren    = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
                i_d     = i_q + 8'd1;
                kidx_d  = (kidx_q == KW'(KEY_LENGTH-1)) ? '0 : kidx_q + KW'(1);
                state_d = (i_q == 8'(S_SIZE-1)) ? DONE : RD_I;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_ksa_shuffle.sv
// tb_ksa_shuffle: randomized self-checking bench against a software RC4 KSA model.
module tb_ksa_shuffle;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  q, address, data, aq;
    logic        wren, busy, done;
    logic [7:0]  mem [256];
    logic [7:0]  pre [256];
    logic [7:0]  fin [256];
    logic [7:0]  snap [256];
    bit          ld = 1'b0;
    int          npass = 0, ntot = 0;
    int          ea[$], ed[$];
    int          fw_a[4], fw_d[4];

    always #5 clk = ~clk;

    ksa_shuffle #(.KEY_LENGTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .done       (done)
    );

    // S RAM: registered address, combinational read data.
    assign q = mem[aq];
    always @(posedge clk) begin
        aq <= address;
        if (ld) for (int k = 0; k < 256; k++) mem[k] <= pre[k];
        else if (wren) mem[address] <= data;
    end

    task automatic chk(input string n, input int a, input int e);
        ntot++;
        if (a == e) npass++;
        else $display("FAIL %s: got %0d expected %0d", n, a, e);
    endtask

    function automatic int kb(input logic [23:0] key, input int i);
        return int'((key >> (8 * (2 - i % 3))) & 24'hFF);
    endfunction

    function automatic int model_at(input logic [23:0] key, input int n, input int idx);
        int s[256];
        int j = 0, t;
        for (int k = 0; k < 256; k++) s[k] = int'(pre[k]);
        for (int i = 0; i < n; i++) begin
            j = (j + s[i] + kb(key, i)) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        return s[idx];
    endfunction

    task automatic build(input logic [23:0] key);
        int s[256];
        int j = 0, t;
        ea.delete(); ed.delete();
        for (int k = 0; k < 256; k++) s[k] = int'(pre[k]);
        for (int i = 0; i < 256; i++) begin
            j = (j + s[i] + kb(key, i)) % 256;
            ea.push_back(i); ed.push_back(s[j]);
            ea.push_back(j); ed.push_back(s[i]);
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int k = 0; k < 256; k++) fin[k] = 8'(s[k]);
    endtask

    task automatic run(input logic [23:0] key, input int abort_at, input int restart_at);
        int  wcnt = 0, nbad = 0, a, d;
        bit  aborted = 1'b0;
        bit  wexp;
        build(key);
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 1537; k++) begin
            start = (k == restart_at);
            if (k == 19) snap = mem;
            wexp = (k <= 1536) && (k % 6 == 5 || k % 6 == 0);
            if (k == abort_at) begin
                #1 chk("pre_abort_wren", int'(wren), int'(wexp));
                reset = 1'b1;
                #1;
                chk("abort_wren", int'(wren), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_addr", int'(address), 0);
                @(negedge clk) reset = 1'b0;
                @(negedge clk);
                chk("abort_idle_busy", int'(busy), 0);
                chk("abort_idle_done", int'(done), 0);
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            chk("busy", int'(busy), int'(k <= 1536));
            chk("done", int'(done), int'(k == 1537));
            chk("wren", int'(wren), int'(wexp));
            if (wren) begin
                a = (ea.size() != 0) ? ea.pop_front() : -1;
                d = (ed.size() != 0) ? ed.pop_front() : -1;
                chk("waddr", int'(address), a);
                chk("wdata", int'(data), d);
                if (wcnt < 4) begin fw_a[wcnt] = int'(address); fw_d[wcnt] = int'(data); end
                wcnt++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (!aborted) begin
            chk("wren_count", wcnt, 512);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            for (int k = 0; k < 256; k++) if (mem[k] !== fin[k]) nbad++;
            chk("final_array", nbad, 0);
        end
    endtask

    task automatic identity();
        for (int k = 0; k < 256; k++) pre[k] = 8'(k);
    endtask

    task automatic permute();
        int r;
        logic [7:0] t;
        identity();
        for (int k = 255; k > 0; k--) begin
            r = int'($urandom_range(k, 0));
            t = pre[k]; pre[k] = pre[r]; pre[r] = t;
        end
    endtask

    initial begin
        logic [23:0] key;
        logic [7:0]  t;
        int          v;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", int'(address), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_wren", int'(wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk) reset = 1'b0;

        identity();
        chk("model_k249_s0", model_at(24'h000249, 3, 0), 0);
        chk("model_k249_s1", model_at(24'h000249, 3, 1), 3);
        chk("model_k249_s3", model_at(24'h000249, 3, 3), 1);
        chk("model_k249_s2", model_at(24'h000249, 3, 2), 8'h4E);
        chk("model_k249_s4e", model_at(24'h000249, 3, 8'h4E), 2);
        chk("model_k0_s2", model_at(24'h000000, 3, 2), 3);
        chk("model_k0_s3", model_at(24'h000000, 3, 3), 2);

        run(24'h000249, 0, 0);
        chk("dut_k249_s0", int'(snap[0]), 0);
        chk("dut_k249_s1", int'(snap[1]), 3);
        chk("dut_k249_s3", int'(snap[3]), 1);
        chk("dut_k249_s2", int'(snap[2]), 8'h4E);
        chk("dut_k249_s4e", int'(snap[8'h4E]), 2);

        run(24'h000000, 0, 0);
        chk("dut_k0_s1", int'(snap[1]), 1);
        chk("dut_k0_s2", int'(snap[2]), 3);
        chk("dut_k0_s3", int'(snap[3]), 2);
        chk("k0_w2_addr", fw_a[2], 1);
        chk("k0_w3_addr", fw_a[3], 1);
        chk("k0_w3_data", fw_d[3], 1);

        key = 24'($urandom());
        run(key, 0, 100);

        key = 24'($urandom());
        identity();
        run(key, 700, 0);
        run(key, 0, 0);
        run(key, 701, 0);
        run(key, 0, 0);

        for (int r = 0; r < 2; r++) begin
            permute();
            run(24'($urandom()), 0, 0);
        end

        // Preload so that iteration 0 lands j on 0.
        key = 24'($urandom());
        permute();
        v = (256 - kb(key, 0)) % 256;
        for (int k = 0; k < 256; k++)
            if (int'(pre[k]) == v) begin t = pre[0]; pre[0] = pre[k]; pre[k] = t; end
        run(key, 0, 0);
        chk("ieqj_w0_addr", fw_a[0], 0);
        chk("ieqj_w1_addr", fw_a[1], 0);
        chk("ieqj_w0_data", fw_d[0], int'(pre[0]));
        chk("ieqj_w1_data", fw_d[1], int'(pre[0]));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
